// File: rtl/match_sequencer.sv
// Pong match sequencer: idle, serve countdown, rally, post-point hold and game over,
// with score keeping, win detection and control of the ball datapath.
module match_sequencer #(
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SERVE_DELAY_MS = 1000,
    parameter int unsigned POINT_HOLD_MS  = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       start,
    input  logic       pause,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       p1_win,
    output logic       p2_win,
    output logic       game_end
);

    localparam int unsigned MS_MAX = (SERVE_DELAY_MS > POINT_HOLD_MS) ? SERVE_DELAY_MS : POINT_HOLD_MS;
    localparam int unsigned MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    localparam logic [3:0]      WIN        = 4'(WIN_SCORE);
    localparam logic [MS_W-1:0] SERVE_LAST = MS_W'(SERVE_DELAY_MS - 1);
    localparam logic [MS_W-1:0] HOLD_LAST  = MS_W'(POINT_HOLD_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RALLY     = 3'd2,
        S_POINT     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    state_t          st;
    logic            start_q;
    logic            start_edge;
    logic            timer_step;
    logic [MS_W-1:0] ms_cnt;

    // start_q powers up high so a button held through reset never counts as a press
    assign start_edge = start & ~start_q;
    assign timer_step = tick_1ms & ~pause;
    assign state      = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            start_q    <= 1'b1;
            ms_cnt     <= '0;
            countdown  <= 2'd0;
            ball_run   <= 1'b0;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            p1_win     <= 1'b0;
            p2_win     <= 1'b0;
            game_end   <= 1'b0;
        end else begin
            start_q <= start;
            unique case (st)
                S_IDLE, S_OVER: begin
                    ball_run   <= 1'b0;
                    ball_reset <= 1'b1;
                    if (start_edge) begin
                        st        <= S_COUNTDOWN;
                        ms_cnt    <= '0;
                        countdown <= 2'd3;
                        p1_score  <= 4'd0;
                        p2_score  <= 4'd0;
                        p1_win    <= 1'b0;
                        p2_win    <= 1'b0;
                        game_end  <= 1'b0;
                    end
                end

                S_COUNTDOWN: begin
                    if (timer_step) begin
                        if (ms_cnt == SERVE_LAST) begin
                            ms_cnt    <= '0;
                            countdown <= countdown - 2'd1;
                            if (countdown == 2'd1) begin
                                st         <= S_RALLY;
                                ball_run   <= 1'b1;
                                ball_reset <= 1'b0;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end
                end

                S_RALLY: begin
                    ball_run <= ~pause;
                    // simultaneous pulses re-serve without touching score or serve side
                    if (p1_point || p2_point) begin
                        st         <= S_POINT;
                        ms_cnt     <= '0;
                        ball_run   <= 1'b0;
                        ball_reset <= 1'b1;
                        if (p1_point && !p2_point) begin
                            serve_dir <= 1'b0;
                            if (p1_score < WIN) p1_score <= p1_score + 4'd1;
                        end else if (p2_point && !p1_point) begin
                            serve_dir <= 1'b1;
                            if (p2_score < WIN) p2_score <= p2_score + 4'd1;
                        end
                    end
                end

                S_POINT: begin
                    if (timer_step) begin
                        if (ms_cnt == HOLD_LAST) begin
                            ms_cnt <= '0;
                            if (p1_score == WIN || p2_score == WIN) begin
                                st       <= S_OVER;
                                game_end <= 1'b1;
                                p1_win   <= (p1_score == WIN);
                                p2_win   <= (p2_score == WIN);
                            end else begin
                                st        <= S_COUNTDOWN;
                                countdown <= 2'd3;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + MS_W'(1);
                        end
                    end
                end

                default: begin
                    st         <= S_IDLE;
                    ms_cnt     <= '0;
                    ball_run   <= 1'b0;
                    ball_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed match scenarios followed by
// random stimulus, every cycle compared against a tick-budget reference model.
module tb_match_sequencer;

    localparam int WIN = 2;
    localparam int SD  = 2;
    localparam int PH  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1ms = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [2:0] state;
    logic [1:0] countdown;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       p1_win;
    logic       p2_win;
    logic       game_end;

    match_sequencer #(
        .WIN_SCORE     (WIN),
        .SERVE_DELAY_MS(SD),
        .POINT_HOLD_MS (PH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1ms  (tick_1ms),
        .start     (start),
        .pause     (pause),
        .p1_point  (p1_point),
        .p2_point  (p2_point),
        .state     (state),
        .countdown (countdown),
        .ball_run  (ball_run),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .p1_win    (p1_win),
        .p2_win    (p2_win),
        .game_end  (game_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail_printed = 0;

    // Reference model: phase plus remaining millisecond budgets rather than step counters
    int m_state   = 0;
    int m_cd_left = 0;
    int m_hold    = 0;
    int m_p1      = 0;
    int m_p2      = 0;
    int m_serve   = 0;
    int m_run     = 0;
    int m_start_q = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            if (n_fail_printed < 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
            n_fail_printed++;
        end
    endtask

    function automatic void model_update();
        int se;
        se = (start && !m_start_q) ? 1 : 0;
        m_start_q = start ? 1 : 0;
        if (reset) begin
            m_state = 0; m_cd_left = 0; m_hold = 0; m_p1 = 0; m_p2 = 0;
            m_serve = 0; m_run = 0; m_start_q = 1;
            return;
        end
        case (m_state)
            0, 4: if (se == 1) begin
                m_p1 = 0; m_p2 = 0; m_state = 1; m_cd_left = 3 * SD;
            end
            1: if (tick_1ms && !pause) begin
                m_cd_left--;
                if (m_cd_left == 0) m_state = 2;
            end
            2: if (p1_point || p2_point) begin
                if (p1_point && !p2_point) begin
                    m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1; m_serve = 0;
                end else if (p2_point && !p1_point) begin
                    m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1; m_serve = 1;
                end
                m_state = 3; m_hold = PH;
            end
            3: if (tick_1ms && !pause) begin
                m_hold--;
                if (m_hold == 0) begin
                    if (m_p1 == WIN || m_p2 == WIN) m_state = 4;
                    else begin m_state = 1; m_cd_left = 3 * SD; end
                end
            end
            default: m_state = 0;
        endcase
        m_run = (m_state == 2 && !pause) ? 1 : 0;
    endfunction

    task automatic compare_all();
        int exp_cd;
        exp_cd = (m_state == 1) ? (m_cd_left + SD - 1) / SD : 0;
        check("state", 32'(state), 32'(m_state));
        check("countdown", 32'(countdown), 32'(exp_cd));
        check("ball_run", 32'(ball_run), 32'(m_run));
        check("ball_reset", 32'(ball_reset), (m_state != 2) ? 32'd1 : 32'd0);
        check("serve_dir", 32'(serve_dir), 32'(m_serve));
        check("p1_score", 32'(p1_score), 32'(m_p1));
        check("p2_score", 32'(p2_score), 32'(m_p2));
        check("p1_win", 32'(p1_win), (m_state == 4 && m_p1 == WIN) ? 32'd1 : 32'd0);
        check("p2_win", 32'(p2_win), (m_state == 4 && m_p2 == WIN) ? 32'd1 : 32'd0);
        check("game_end", 32'(game_end), (m_state == 4) ? 32'd1 : 32'd0);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1ms = 1'b1; step();
            tick_1ms = 1'b0; step();
        end
    endtask

    task automatic pulse(input logic a, input logic b);
        p1_point = a; p2_point = b; step();
        p1_point = 1'b0; p2_point = 1'b0;
    endtask

    task automatic press();
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    initial begin
        // 1: start held through reset must not register as a press
        reset = 1'b1; start = 1'b1;
        repeat (3) step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ball_reset", 32'(ball_reset), 32'd1);
        reset = 1'b0;
        tick_n(10);
        check("held_start_idle", 32'(state), 32'd0);
        start = 1'b0; step();
        start = 1'b1; step();
        check("start_to_cd", 32'(state), 32'd1);
        check("start_cd3", 32'(countdown), 32'd3);
        start = 1'b0;
        tick_n(6);
        check("cd_to_rally", 32'(state), 32'd2);
        check("rally_run", 32'(ball_run), 32'd1);

        // 2: scoring and serve direction
        pulse(1'b1, 1'b0);
        check("p1_scored", 32'(p1_score), 32'd1);
        check("p1_serve", 32'(serve_dir), 32'd0);
        check("p1_point_state", 32'(state), 32'd3);
        tick_n(3);
        check("hold_to_cd", 32'(state), 32'd1);
        tick_n(6);
        pulse(1'b0, 1'b1);
        check("p2_scored", 32'(p2_score), 32'd1);
        check("p2_serve", 32'(serve_dir), 32'd1);

        // 3: simultaneous points and ignored pulses
        tick_n(3); tick_n(6);
        pulse(1'b1, 1'b1);
        check("both_state", 32'(state), 32'd3);
        check("both_p1", 32'(p1_score), 32'd1);
        pulse(1'b1, 1'b0);
        check("ignored_in_point", 32'(p1_score), 32'd1);
        tick_n(3);
        pulse(1'b0, 1'b1);
        check("ignored_in_cd", 32'(p2_score), 32'd1);
        tick_n(6);

        // 4: win and restart
        pulse(1'b1, 1'b0);
        tick_n(3);
        check("over_state", 32'(state), 32'd4);
        check("over_p1_win", 32'(p1_win), 32'd1);
        check("over_p2_win", 32'(p2_win), 32'd0);
        check("over_game_end", 32'(game_end), 32'd1);
        pulse(1'b0, 1'b1);
        check("ignored_in_over", 32'(p2_score), 32'd1);
        press();
        check("restart_state", 32'(state), 32'd1);
        check("restart_scores", 32'({p1_score, p2_score}), 32'd0);
        check("restart_win", 32'({p1_win, p2_win}), 32'd0);
        check("restart_cd", 32'(countdown), 32'd3);

        // 5: pause freezes countdown and stops the ball
        tick_n(1);
        pause = 1'b1; tick_n(20);
        check("paused_cd", 32'(countdown), 32'd3);
        pause = 1'b0; tick_n(1);
        check("resumed_cd", 32'(countdown), 32'd2);
        tick_n(4);
        pause = 1'b1; step(); step();
        check("pause_rally_state", 32'(state), 32'd2);
        check("pause_rally_run", 32'(ball_run), 32'd0);
        pause = 1'b0; step();
        check("unpause_run", 32'(ball_run), 32'd1);

        // 6: reset in POINT
        pulse(1'b1, 1'b0);
        check("pre_reset_point", 32'(state), 32'd3);
        reset = 1'b1; step();
        check("mid_reset_state", 32'(state), 32'd0);
        check("mid_reset_p1", 32'(p1_score), 32'd0);
        reset = 1'b0; step();

        // random play
        for (int c = 0; c < 4000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            tick_1ms = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 14) == 0) start = ~start;
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            p1_point = ($urandom_range(0, 11) == 0);
            p2_point = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/match_sequencer.md
# match_sequencer

Sequences a Pong match: idle, pre-serve countdown, rally, post-point hold and game-over, with score keeping and win detection. It sits between the button inputs, the ball datapath, the seven-segment score display and the LEDs. It consumes point pulses from the ball and drives that datapath's run/reset/serve controls. All logic is in the single system clock domain; the 1 ms timebase arrives as a one-cycle enable pulse.

## Interface
Parameters:
- WIN_SCORE, 5: points needed to win; legal range 1..15.
- SERVE_DELAY_MS, 1000: milliseconds per countdown step; must be ≥1.
- POINT_HOLD_MS, 500: milliseconds the ball is held reset after a point; must be ≥1.

Ports:
- clk  in  1  system clock. There is one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- tick_1ms  in  1  one-cycle enable pulse, once per millisecond.
- start  in  1  level; OR of all player buttons; rising edge detected internally.
- pause  in  1  level; freezes sequencing while high.
- p1_point  in  1  one-cycle pulse: player 1 scored.
- p2_point  in  1  one-cycle pulse: player 2 scored.
- state  out  3  0=IDLE, 1=COUNTDOWN, 2=RALLY, 3=POINT, 4=OVER.
- countdown  out  2  remaining countdown steps, 3..0, for display.
- ball_run  out  1  ball motion enable.
- ball_reset  out  1  hold the ball at centre.
- serve_dir  out  1  0 = serve toward player 2, 1 = serve toward player 1.
- p1_score, p2_score  out  4 each  current scores.
- p1_win, p2_win  out  1 each  winner flags; held in OVER.
- game_end  out  1  high only in OVER.

## Operation
- Start edge: start_edge = start & ~start_q. start_q resets to 1, so a button held through reset produces no edge until it has been released.
- IDLE:
  - ball_reset=1, ball_run=0.
  - start_edge clears both scores and goes to COUNTDOWN with countdown=3 and ms_cnt=0.
- COUNTDOWN:
  - ball_reset=1.
  - On each tick_1ms with pause=0, ms_cnt increments.
  - When ms_cnt reaches SERVE_DELAY_MS-1 on a tick, ms_cnt is cleared and countdown is decremented.
  - The decrement from 1 to 0 moves the block to RALLY.
- RALLY:
  - ball_run = ~pause; ball_reset=0.
  - p1_point alone: p1_score+1, serve_dir←0, go to POINT.
  - p2_point alone: p2_score+1, serve_dir←1, go to POINT.
  - Both pulses in the same cycle: no score change, serve_dir unchanged, go to POINT (re-serve).
  - Point pulses are ignored in every state except RALLY.
  - Point pulses are still accepted while paused.
- POINT:
  - ball_reset=1, ball_run=0.
  - ms_cnt counts ticks (frozen while pause=1) up to POINT_HOLD_MS-1.
  - At expiry: if either score equals WIN_SCORE, go to OVER; otherwise go to COUNTDOWN with countdown=3.
- OVER:
  - game_end=1, ball_reset=1.
  - p1_win = (p1_score==WIN_SCORE) and p2_win = (p2_score==WIN_SCORE); the two are mutually exclusive by construction.
  - start_edge clears the scores and win flags and goes to COUNTDOWN with countdown=3.
- Arithmetic: scores are 4-bit and saturate at WIN_SCORE. ms_cnt width is $clog2(max(SERVE_DELAY_MS, POINT_HOLD_MS)). ms_cnt is cleared on every state entry.
- The pause input never changes state and never alters scores.

## Timing
- All outputs are registered and are updated on the clk edge on which the triggering condition is sampled.
- Reset values: state=IDLE, countdown=0, ball_run=0, ball_reset=1, serve_dir=0, scores=0, p1_win=p2_win=0, game_end=0.
- Reset asserted mid-operation returns every output to its reset value on the next clock edge, regardless of state.
- Point-to-score latency: the score and state update on the edge that samples the point pulse, so they are visible one cycle after the pulse.
- ball_run falls on the same edge that state becomes POINT.
- COUNTDOWN duration: exactly 3×SERVE_DELAY_MS ticks with pause=0. ball_run rises on the edge that samples the final tick.
- POINT duration: exactly POINT_HOLD_MS ticks.
- A tick_1ms coincident with a state entry is not counted toward the new state's timer.

## Test plan
Run with WIN_SCORE=2, SERVE_DELAY_MS=2, POINT_HOLD_MS=3.

1. Start-edge gating: hold start high through reset release, then keep it high for 10 ticks → state stays 0. Release start and press again → state=1, countdown=3. After 6 ticks → state=2, ball_run=1.
2. Scoring and serve: in RALLY, pulse p1_point → p1_score=1, serve_dir=0, state=3. After 3 ticks → state=1. Pulse p2_point in the next RALLY → p2_score=1, serve_dir=1.
3. Simultaneous points: pulse p1_point and p2_point in the same cycle during RALLY → scores unchanged, state=3. Pulses arriving in COUNTDOWN or POINT → ignored.
4. Win and restart: p1 scores twice → after the POINT hold, state=4, game_end=1, p1_win=1, p2_win=0. Further point pulses → ignored. A start edge → scores=0, win flags=0, state=1, countdown=3.
5. Pause: raise pause in COUNTDOWN for 20 ticks → countdown frozen. Raise pause in RALLY → ball_run=0 and state stays 2. Release pause → sequencing resumes from the frozen ms_cnt.
6. Reset mid-operation: assert reset in POINT with p1_score=1 → on the next edge all outputs equal their reset values.
